// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller: applies up to STEP bits of shift per cycle until shamt is consumed.
// Optional feature macro SHIFT_SEQ_ROTATE_EN: op 11 rotates right instead of passing the operand through.
module shift_sequencer #(
  parameter  int WIDTH = 32,
  parameter  int STEP  = 4,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_data,
  input  logic [SHW-1:0]   req_shamt,
  input  logic [1:0]       req_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROR = 2'b11
  } op_e;

  localparam logic [SHW-1:0] STEP_N = SHW'(STEP);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SHW-1:0]   rem_q, rem_d;
  logic [SHW-1:0]   step_n;
  logic [WIDTH-1:0] shifted;

  // Bits consumed this cycle; never exceeds what is left, so rem_q cannot wrap.
  assign step_n = (rem_q > STEP_N) ? STEP_N : rem_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    shifted = acc_q;
    case (op_q)
      OP_SLL: shifted = acc_q << step_n;
      OP_SRL: shifted = acc_q >> step_n;
      OP_SRA: shifted = $signed(acc_q) >>> step_n;
`ifdef SHIFT_SEQ_ROTATE_EN
      OP_ROR: shifted = (acc_q >> step_n) | (acc_q << ((SHW+1)'(WIDTH) - {1'b0, step_n}));
`else
      OP_ROR: shifted = acc_q;
`endif
      default: shifted = acc_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          acc_d   = req_data;
          rem_d   = req_shamt;
          op_d    = op_e'(req_op);
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (rem_q == '0) begin
          state_d = S_DONE;
        end else begin
          acc_d = shifted;
          rem_d = rem_q - step_n;
        end
      end
      S_DONE: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= OP_SLL;
      acc_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
    end
  end

  // Outputs decode registered state only; nothing flows combinationally from the inputs.
  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign rsp_data  = acc_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: STEP=4 main instance plus a STEP=1 instance for the long-latency case.
module tb_shift_sequencer;

  logic        clk;
  logic        rst_n;
  logic        req_valid, req_ready, rsp_valid, rsp_ready, busy;
  logic [31:0] req_data, rsp_data;
  logic [4:0]  req_shamt;
  logic [1:0]  req_op;

  logic        u_req_valid, u_req_ready, u_rsp_valid, u_rsp_ready, u_busy;
  logic [31:0] u_req_data, u_rsp_data;
  logic [4:0]  u_req_shamt;
  logic [1:0]  u_req_op;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_acc  = 0;

  shift_sequencer #(.WIDTH(32), .STEP(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .req_shamt(req_shamt), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .busy(busy)
  );

  shift_sequencer #(.WIDTH(32), .STEP(1)) dut_step1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(u_req_valid), .req_ready(u_req_ready), .req_data(u_req_data),
    .req_shamt(u_req_shamt), .req_op(u_req_op),
    .rsp_valid(u_rsp_valid), .rsp_ready(u_rsp_ready), .rsp_data(u_rsp_data),
    .busy(u_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Accepted-request counter for the main instance.
  always @(posedge clk) if (req_valid && req_ready) n_acc++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for rsp_valid after an accept edge, checks latency and data,
  // and completes the handshake when rsp_ready is already high.
  task automatic wait_rsp(input logic [31:0] exp, input int exp_lat, input string tag);
    int lat;
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 200) begin
      tick();
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_data"}, rsp_data, exp);
    if (rsp_ready) begin
      tick();
      check({tag, "_rdy_back"}, {31'd0, req_ready}, 32'd1);
    end
  endtask

  task automatic do_req(input logic [1:0] op, input logic [31:0] data, input logic [4:0] shamt,
                        input logic [31:0] exp, input int exp_lat, input string tag);
    check({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_data  = data;
    req_shamt = shamt;
    tick();
    req_valid = 1'b0;
    wait_rsp(exp, exp_lat, tag);
  endtask

  initial begin
    int          base;
    int          lat;
    int          stray;
    logic [31:0] ror_exp0, ror_exp1;

`ifdef SHIFT_SEQ_ROTATE_EN
    ror_exp0 = 32'hF000_0000;
    ror_exp1 = 32'h7812_3456;
`else
    ror_exp0 = 32'h0000_000F;
    ror_exp1 = 32'h1234_5678;
`endif

    rst_n = 1'b0;
    req_valid = 1'b0; req_data = '0; req_shamt = '0; req_op = '0; rsp_ready = 1'b0;
    u_req_valid = 1'b0; u_req_data = '0; u_req_shamt = '0; u_req_op = '0; u_rsp_ready = 1'b1;
    repeat (2) tick();

    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_busy",      {31'd0, busy},      32'd0);
    check("rst_rsp_data",  rsp_data,           32'd0);

    rst_n = 1'b1;
    tick();
    rsp_ready = 1'b1;

    // Basic shifts and boundaries.
    do_req(2'b00, 32'h0000_0001, 5'd4,  32'h0000_0010, 2, "sll4");
    do_req(2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 9, "sra31");
    do_req(2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001, 9, "srl31");
    do_req(2'b00, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1, "sll0");
    do_req(2'b10, 32'h7000_0000, 5'd5,  32'h0380_0000, 3, "sra_pos5");
    do_req(2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000, 9, "sll31");
    do_req(2'b11, 32'h0000_000F, 5'd4,  ror_exp0,      2, "op11_4");
    do_req(2'b11, 32'h1234_5678, 5'd8,  ror_exp1,      3, "op11_8");

    // STEP=1 instance: one bit per cycle.
    u_req_valid = 1'b1; u_req_op = 2'b00; u_req_data = 32'h1; u_req_shamt = 5'd31;
    tick();
    u_req_valid = 1'b0;
    lat = 0;
    while (u_rsp_valid !== 1'b1 && lat < 200) begin
      tick();
      lat++;
    end
    check("step1_lat",  32'(lat), 32'd32);
    check("step1_data", u_rsp_data, 32'h8000_0000);

    // Backpressure in DONE with a second request held waiting.
    rsp_ready = 1'b0;
    do_req(2'b00, 32'h0000_0001, 5'd8, 32'h0000_0100, 3, "bp_first");
    req_valid = 1'b1; req_op = 2'b01; req_data = 32'h0000_0080; req_shamt = 5'd4;
    base = n_acc;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("bp_hold%0d_valid", i), {31'd0, rsp_valid}, 32'd1);
      check($sformatf("bp_hold%0d_data", i),  rsp_data,           32'h0000_0100);
      check($sformatf("bp_hold%0d_ready", i), {31'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    check("bp_idle_ready", {31'd0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
    wait_rsp(32'h0000_0008, 2, "bp_second");
    check("bp_accept_once", 32'(n_acc - base), 32'd1);

    // Reset in the middle of RUN discards the operation.
    req_valid = 1'b1; req_op = 2'b01; req_data = 32'hFFFF_0000; req_shamt = 5'd16;
    tick();
    req_valid = 1'b0;
    tick();
    check("mid_busy_run", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
    check("mid_rst_busy",  {31'd0, busy},      32'd0);
    tick();
    rst_n = 1'b1;
    check("mid_rel_ready", {31'd0, req_ready}, 32'd1);
    check("mid_rel_data",  rsp_data,           32'd0);
    stray = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (rsp_valid === 1'b1 || busy === 1'b1) stray++;
    end
    check("mid_no_stale", 32'(stray), 32'd0);

    do_req(2'b01, 32'hFFFF_0000, 5'd16, 32'h0000_FFFF, 5, "post_rst_srl16");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
